// File: rtl/sw_sequencer.sv
// Stopwatch control sequencer: button edge detect, run/split/pause FSM, tick prescaler.
// Optional lap counter on lap_num enabled by defining SW_SEQUENCER_LAP_COUNT_EN.
module sw_sequencer #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trig,
    input  logic       split,
    output logic       init_regs,
    output logic       count_enabled,
    output logic       count_tick,
    output logic       display_hold,
    output logic       lap_capture,
    output logic [3:0] lap_num
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_SPLIT    = 2'd2,
        ST_PAUSED   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_trig_q;
    logic r_split_q;
    logic w_trig_p;
    logic w_split_p;

    logic [PRESC_W-1:0] r_presc;

    logic r_init_regs;
    logic r_count_enabled;
    logic r_count_tick;
    logic r_display_hold;
    logic r_lap_capture;

    logic w_init_regs;
    logic w_count_enabled;
    logic w_display_hold;
    logic w_lap_capture;
    logic w_run;
    logic w_wrap;

    // Previous levels reset high so a button held through reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trig_q  <= 1'b1;
            r_split_q <= 1'b1;
        end else begin
            r_trig_q  <= trig;
            r_split_q <= split;
        end
    end

    assign w_trig_p  = trig & ~r_trig_q;
    assign w_split_p = split & ~r_split_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Start/stop always wins over split when both rise together.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trig_p) w_state_nxt = ST_COUNTING;
            end
            ST_COUNTING: begin
                if (w_trig_p)       w_state_nxt = ST_PAUSED;
                else if (w_split_p) w_state_nxt = ST_SPLIT;
            end
            ST_SPLIT: begin
                if (w_trig_p)       w_state_nxt = ST_PAUSED;
                else if (w_split_p) w_state_nxt = ST_COUNTING;
            end
            ST_PAUSED: begin
                if (w_trig_p)       w_state_nxt = ST_COUNTING;
                else if (w_split_p) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track the state register.
    always_comb begin
        w_init_regs     = 1'b0;
        w_count_enabled = 1'b0;
        w_display_hold  = 1'b0;
        w_lap_capture   = 1'b0;
        case (w_state_nxt)
            ST_IDLE:     w_init_regs = 1'b1;
            ST_COUNTING: w_count_enabled = 1'b1;
            ST_SPLIT: begin
                w_count_enabled = 1'b1;
                w_display_hold  = 1'b1;
                w_lap_capture   = (r_state == ST_COUNTING);
            end
            default: ;
        endcase
    end

    // Prescaler advances only across cycles that stay enabled, so a pause freezes its phase.
    assign w_run  = r_count_enabled & w_count_enabled;
    assign w_wrap = w_run & (r_presc == PRESC_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_init_regs || w_wrap) begin
            r_presc <= '0;
        end else if (w_run) begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_init_regs     <= 1'b1;
            r_count_enabled <= 1'b0;
            r_count_tick    <= 1'b0;
            r_display_hold  <= 1'b0;
            r_lap_capture   <= 1'b0;
        end else begin
            r_init_regs     <= w_init_regs;
            r_count_enabled <= w_count_enabled;
            r_count_tick    <= w_wrap;
            r_display_hold  <= w_display_hold;
            r_lap_capture   <= w_lap_capture;
        end
    end

    assign init_regs     = r_init_regs;
    assign count_enabled = r_count_enabled;
    assign count_tick    = r_count_tick;
    assign display_hold  = r_display_hold;
    assign lap_capture   = r_lap_capture;

`ifdef SW_SEQUENCER_LAP_COUNT_EN
    logic [3:0] r_lap_num;

    // Saturating lap count, updated alongside the lap strobe and cleared on return to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lap_num <= 4'd0;
        end else if (w_init_regs) begin
            r_lap_num <= 4'd0;
        end else if (w_lap_capture && (r_lap_num != 4'd15)) begin
            r_lap_num <= r_lap_num + 4'd1;
        end
    end

    assign lap_num = r_lap_num;
`else
    assign lap_num = 4'd0;
`endif

endmodule

// File: tb/tb_sw_sequencer.sv
// Self-checking bench for sw_sequencer (TICK_DIV=4): stopwatch behaviour model plus directed literals.
module tb_sw_sequencer;

    localparam int unsigned TICK_DIV = 4;
`ifdef SW_SEQUENCER_LAP_COUNT_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       trig  = 1'b0;
    logic       split = 1'b0;
    logic       init_regs;
    logic       count_enabled;
    logic       count_tick;
    logic       display_hold;
    logic       lap_capture;
    logic [3:0] lap_num;

    int n_chk = 0;
    int n_err = 0;

    sw_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .trig          (trig),
        .split         (split),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .count_tick    (count_tick),
        .display_hold  (display_hold),
        .lap_capture   (lap_capture),
        .lap_num       (lap_num)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stopwatch model: running / display frozen / cleared flags and an elapsed-cycle phase.
    bit m_prev_t  = 1'b1;
    bit m_prev_s  = 1'b1;
    bit m_running = 1'b0;
    bit m_hold    = 1'b0;
    bit m_cleared = 1'b1;
    bit m_cap     = 1'b0;
    bit m_tick    = 1'b0;
    int m_phase   = 0;
    int m_laps    = 0;

    always @(posedge clk or posedge reset) begin
        bit tp;
        bit sp;
        bit run_next;
        if (reset) begin
            m_prev_t  = 1'b1;
            m_prev_s  = 1'b1;
            m_running = 1'b0;
            m_hold    = 1'b0;
            m_cleared = 1'b1;
            m_cap     = 1'b0;
            m_tick    = 1'b0;
            m_phase   = 0;
            m_laps    = 0;
        end else begin
            tp       = trig && !m_prev_t;
            sp       = split && !m_prev_s;
            m_prev_t = trig;
            m_prev_s = split;
            m_cap    = 1'b0;
            m_tick   = 1'b0;
            run_next = m_running;
            if (tp) begin
                run_next  = !m_running;
                m_cleared = 1'b0;
                m_hold    = 1'b0;
            end else if (sp) begin
                if (m_running) begin
                    m_hold = !m_hold;
                    if (m_hold) begin
                        m_cap = 1'b1;
                        if (m_laps < 15) m_laps++;
                    end
                end else if (!m_cleared) begin
                    m_cleared = 1'b1;
                    m_phase   = 0;
                    m_laps    = 0;
                end
            end
            if (m_running && run_next) begin
                m_phase = (m_phase + 1) % TICK_DIV;
                if (m_phase == 0) m_tick = 1'b1;
            end
            m_running = run_next;
        end
    end

    always @(negedge clk) begin
        chk("model init_regs",     32'(init_regs),     32'(m_cleared));
        chk("model count_enabled", 32'(count_enabled), 32'(m_running));
        chk("model count_tick",    32'(count_tick),    32'(m_tick));
        chk("model display_hold",  32'(display_hold),  32'(m_running && m_hold));
        chk("model lap_capture",   32'(lap_capture),   32'(m_cap));
        chk("model lap_num",       32'(lap_num),       LAP_EN ? 32'(m_laps) : 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input bit t, input bit s);
        trig  = t;
        split = s;
        step();
        trig  = 1'b0;
        split = 1'b0;
    endtask

    initial begin
        int nticks;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset init_regs", 32'(init_regs), 32'd1);
        chk("reset count_enabled", 32'(count_enabled), 32'd0);
        chk("reset lap_num", 32'(lap_num), 32'd0);
        step();
        reset = 1'b0;
        step();

        // start: enable one cycle after the press, ticks at 4, 8, 12
        pulse(1'b1, 1'b0);
        @(negedge clk);
        chk("start count_enabled", 32'(count_enabled), 32'd1);
        chk("start init_regs", 32'(init_regs), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            step();
            @(negedge clk);
            chk("start tick phase", 32'(count_tick), 32'((i % 4) == 0));
        end

        // pause with prescaler at 2, then resume: first tick 2 cycles later
        step();
        step();
        pulse(1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step();
            @(negedge clk);
            chk("paused no tick", 32'(count_tick), 32'd0);
        end
        chk("paused count_enabled", 32'(count_enabled), 32'd0);
        pulse(1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step();
            @(negedge clk);
            chk("resume tick phase", 32'(count_tick), 32'(i == 2 || i == 6));
        end

        // split while counting
        pulse(1'b0, 1'b1);
        @(negedge clk);
        chk("split lap_capture", 32'(lap_capture), 32'd1);
        chk("split display_hold", 32'(display_hold), 32'd1);
        nticks = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            @(negedge clk);
            chk("split strobe once", 32'(lap_capture), 32'd0);
            if (count_tick) nticks++;
        end
        chk("split ticks keep running", 32'(nticks), 32'd1);
        pulse(1'b0, 1'b1);
        @(negedge clk);
        chk("unsplit display_hold", 32'(display_hold), 32'd0);
        chk("unsplit lap_num", 32'(lap_num), LAP_EN ? 32'd1 : 32'd0);
        step();

        // simultaneous trig and split: trig wins
        pulse(1'b1, 1'b1);
        @(negedge clk);
        chk("both count_enabled", 32'(count_enabled), 32'd0);
        chk("both lap_capture", 32'(lap_capture), 32'd0);
        chk("both display_hold", 32'(display_hold), 32'd0);
        step();

        // clear from paused, then restart from prescaler 0
        pulse(1'b0, 1'b1);
        @(negedge clk);
        chk("clear init_regs", 32'(init_regs), 32'd1);
        chk("clear lap_num", 32'(lap_num), 32'd0);
        step();
        pulse(1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            @(negedge clk);
            chk("restart tick phase", 32'(count_tick), 32'(i == 4));
        end

        // 17 laps saturate the counter
        for (int i = 0; i < 34; i++) begin
            pulse(1'b0, 1'b1);
            step();
        end
        @(negedge clk);
        chk("lap saturate", 32'(lap_num), LAP_EN ? 32'd15 : 32'd0);

        // async reset mid-split with trig held through release
        step();
        pulse(1'b0, 1'b1);
        step();
        trig = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("async init_regs", 32'(init_regs), 32'd1);
        chk("async count_enabled", 32'(count_enabled), 32'd0);
        chk("async display_hold", 32'(display_hold), 32'd0);
        chk("async lap_capture", 32'(lap_capture), 32'd0);
        chk("async count_tick", 32'(count_tick), 32'd0);
        chk("async lap_num", 32'(lap_num), 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("held trig no start", 32'(count_enabled), 32'd0);
        end
        step();
        trig = 1'b0;
        step();
        pulse(1'b1, 1'b0);
        @(negedge clk);
        chk("rearm start", 32'(count_enabled), 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
